// File: rtl/axil_reg_pkg.sv
// Shared constants, types and the byte-strobe merge helper for the AXI4-Lite register slave.
package axil_reg_pkg;

  localparam int DATA_W    = 32;
  localparam int STRB_W    = DATA_W / 8;
  localparam int NUM_REG   = 16;
  localparam int REG_IDX_W = 4;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  // Write address as held between the AW and W handshakes.
  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic                 err;
  } aw_hold_t;

  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_d,
    input logic [DATA_W-1:0] new_d,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] merged;
    merged = old_d;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) merged[8*k +: 8] = new_d[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/s_axil_register_if.sv
// AXI4-Lite bus bundle for s_axil_register; master drives requests, slave drives responses.
interface s_axil_register_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axil_reg_bank.sv
// 16 x 32-bit register array: one byte-strobed write port and one registered read port.
module axil_reg_bank
  import axil_reg_pkg::*;
#(
  parameter int N_REG = NUM_REG
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_wr_idx,
  input  logic [DATA_W-1:0]    i_wr_data,
  input  logic [STRB_W-1:0]    i_wr_strb,
  input  logic                 i_rd_en,
  input  logic                 i_rd_err,
  input  logic [REG_IDX_W-1:0] i_rd_idx,
  output logic [DATA_W-1:0]    o_rd_data
);

  logic [DATA_W-1:0] r_mem [N_REG];

  // Read and write share an edge; the read samples the pre-write contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_REG; i++) r_mem[i] <= '0;
      o_rd_data <= '0;
    end else begin
      if (i_we) r_mem[i_wr_idx] <= strb_merge(r_mem[i_wr_idx], i_wr_data, i_wr_strb);
      if (i_rd_en) o_rd_data <= i_rd_err ? '0 : r_mem[i_rd_idx];
    end
  end

endmodule

// File: rtl/s_axil_register.sv
// AXI4-Lite slave with 16 x 32-bit registers; independent write and read paths.
// Define S_AXIL_REGISTER_STRICT_DECODE_EN to answer misaligned/out-of-window accesses with SLVERR.
module s_axil_register #(
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REG          = 16
) (
  input  logic            ACLK,
  input  logic            ARESET,
  s_axil_register_if.slave s_axil
);

  import axil_reg_pkg::*;

  localparam int STRB_WIDTH = S_AXI_DATA_WIDTH / 8;

  logic                        r_awready;
  logic                        r_wready;
  logic                        r_bvalid;
  axi_resp_t                   r_bresp;
  logic                        r_aw_held;
  logic                        r_w_held;
  aw_hold_t                    r_aw;
  logic [S_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0]       r_wstrb;

  logic                        r_arready;
  logic                        r_rvalid;
  axi_resp_t                   r_rresp;

  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_ar_hs;
  logic                        w_aw_err;
  logic                        w_ar_err;
  logic                        w_commit;
  logic                        w_aw_held_nxt;
  logic                        w_w_held_nxt;
  logic                        w_bvalid_nxt;
  logic                        w_rvalid_nxt;
  aw_hold_t                    w_aw_now;
  aw_hold_t                    w_wr_sel;
  logic [S_AXI_DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_WIDTH-1:0]       w_wr_strb;
  logic [S_AXI_DATA_WIDTH-1:0] w_rd_data;

`ifdef S_AXIL_REGISTER_STRICT_DECODE_EN
  assign w_aw_err = (|s_axil.AWADDR[1:0]) | (|s_axil.AWADDR[S_AXI_ADDR_WIDTH-1:6]);
  assign w_ar_err = (|s_axil.ARADDR[1:0]) | (|s_axil.ARADDR[S_AXI_ADDR_WIDTH-1:6]);
`else
  logic w_unused_addr;
  assign w_aw_err      = 1'b0;
  assign w_ar_err      = 1'b0;
  assign w_unused_addr = ^{s_axil.AWADDR[1:0], s_axil.AWADDR[S_AXI_ADDR_WIDTH-1:6],
                           s_axil.ARADDR[1:0], s_axil.ARADDR[S_AXI_ADDR_WIDTH-1:6]};
`endif

  assign w_aw_hs = s_axil.AWVALID & r_awready;
  assign w_w_hs  = s_axil.WVALID  & r_wready;
  assign w_ar_hs = s_axil.ARVALID & r_arready;

  assign w_aw_now = '{idx: s_axil.AWADDR[5:2], err: w_aw_err};

  // A channel counts as present if already held or handshaking this cycle.
  assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

  assign w_wr_sel  = r_aw_held ? r_aw    : w_aw_now;
  assign w_wr_data = r_w_held  ? r_wdata : s_axil.WDATA;
  assign w_wr_strb = r_w_held  ? r_wstrb : s_axil.WSTRB;

  assign w_aw_held_nxt = ~w_commit & (r_aw_held | w_aw_hs);
  assign w_w_held_nxt  = ~w_commit & (r_w_held  | w_w_hs);
  assign w_bvalid_nxt  = w_commit | (r_bvalid & ~s_axil.BREADY);
  assign w_rvalid_nxt  = w_ar_hs  | (r_rvalid & ~s_axil.RREADY);

  // Readies are registered so they stay low during reset and carry no input path.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw      <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_awready <= ~w_aw_held_nxt & ~w_bvalid_nxt;
      r_wready  <= ~w_w_held_nxt  & ~w_bvalid_nxt;
      if (w_aw_hs) r_aw <= w_aw_now;
      if (w_w_hs) begin
        r_wdata <= s_axil.WDATA;
        r_wstrb <= s_axil.WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_sel.err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rvalid  <= w_rvalid_nxt;
      r_arready <= ~w_rvalid_nxt;
      if (w_ar_hs) r_rresp <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  axil_reg_bank #(
    .N_REG (NUM_REG)
  ) u_bank (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_we      (w_commit & ~w_wr_sel.err),
    .i_wr_idx  (w_wr_sel.idx),
    .i_wr_data (w_wr_data),
    .i_wr_strb (w_wr_strb),
    .i_rd_en   (w_ar_hs),
    .i_rd_err  (w_ar_err),
    .i_rd_idx  (s_axil.ARADDR[5:2]),
    .o_rd_data (w_rd_data)
  );

  assign s_axil.AWREADY = r_awready;
  assign s_axil.WREADY  = r_wready;
  assign s_axil.BVALID  = r_bvalid;
  assign s_axil.BRESP   = r_bresp;
  assign s_axil.ARREADY = r_arready;
  assign s_axil.RVALID  = r_rvalid;
  assign s_axil.RRESP   = r_rresp;
  assign s_axil.RDATA   = w_rd_data;

endmodule

// File: doc/s_axil_register.md
Name: s_axil_register

Overview:
AXI4-Lite slave register file: 16 x 32-bit read/write registers at byte offsets 0x00-0x3C. It is the responder end of the team's AXI-Lite register-master bench and is synthesizable for use behind interconnect in the SoC. Write and read channels operate independently and concurrently. There is one outstanding transaction per direction.

Parameters:
S_AXI_DATA_WIDTH, 32, data bus width; must be 32 (WSTRB width = S_AXI_DATA_WIDTH/8)
S_AXI_ADDR_WIDTH, 32, address bus width; only bits [5:2] select a register
NUM_REG, 16, register count; fixed, index width 4

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
AWADDR  in  S_AXI_ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  S_AXI_DATA_WIDTH  write data
WSTRB  in  S_AXI_DATA_WIDTH/8  byte enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  S_AXI_ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  S_AXI_DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, all 16 registers 0, holding flags cleared. Reset mid-transaction abandons it; no response is issued afterwards.
- All ready/valid outputs come from registered state only. There is no combinational input-to-output path.
- Write path flags: aw_held, w_held, BVALID.
  - AWREADY = !aw_held & !BVALID. WREADY = !w_held & !BVALID.
  - AW handshake captures AWADDR[5:2] and sets aw_held. W handshake captures WDATA/WSTRB and sets w_held.
  - AW and W are accepted in either order or in the same cycle.
- Commit: on the edge where both AW and W are available (held, or handshaking that cycle):
  - register[idx] byte lanes with WSTRB[k]=1 are updated; the other lanes are unchanged.
  - BVALID <= 1, BRESP <= OKAY (2'b00), both flags cleared.
  - Latency: BVALID is high in the cycle after the later of the two handshakes.
- BVALID and BRESP are held stable until BREADY. BVALID drops on the B-handshake edge, and AWREADY/WREADY reassert the following cycle.
- WSTRB = 0 still produces an OKAY response with no register change.
- Read path: ARREADY = !RVALID.
  - On AR handshake: RDATA <= register[ARADDR[5:2]], RRESP <= OKAY, RVALID <= 1. Latency is 1 cycle.
  - RDATA, RRESP and RVALID are held stable until RREADY. RVALID drops on the R-handshake edge.
  - RDATA keeps its last value after the handshake.
- Write commit and AR handshake on the same edge to the same register: RDATA returns the pre-write value. A read issued one cycle later returns the new value.
- ARADDR/AWADDR bits [1:0] and bits above [5] are ignored, so decode aliases modulo 0x40.

Optional Feature:
S_AXIL_REGISTER_STRICT_DECODE_EN
- Defined: an address with bits[1:0] != 0, or any bit above [5] set, is an error access.
  - Error write: no register change, BRESP = SLVERR (2'b10).
  - Error read: RDATA = 0, RRESP = SLVERR. Timing is identical to the normal case.
- Undefined: aliasing decode as above; responses are always OKAY.

Decomposition:
- Package axil_reg_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - NUM_REG = 16, REG_IDX_W = 4
  - function for byte-strobe merge of old and new data
- Sub-module axil_reg_bank: register array with async reset, one byte-strobed write port and one synchronous read port. The top module keeps the handshake/response logic.

Test Plan:
- Post-reset read of 0x00..0x3C -> each RDATA = 0x00000000, RRESP = 0; RVALID exactly 1 cycle after the AR handshake.
- Write 0x04 = 0xDEADBEEF, WSTRB = 4'b0101; with AW 3 cycles before W -> BVALID 1 cycle after the W handshake; read 0x04 = 0x00AD00EF.
- Writes 1..16 to 0x00..0x3C with random 0-9 cycle AWVALID/WVALID/BREADY delays; BREADY held low 5 cycles -> BVALID/BRESP stable throughout, AWREADY low until the B handshake; readback 1..16.
- Concurrent streams, writes to 0x00..0x1C and reads from 0x20..0x3C, random RREADY stall -> RDATA stable while RVALID & !RREADY; no cross-path corruption.
- Same-edge write commit of 0x55 and AR to 0x08 (old value 0x11) -> RDATA = 0x11; next read = 0x55.
- ARESET pulsed while BVALID = 1 and RVALID = 1 -> all outputs 0 immediately, all registers read 0. With the STRICT macro: write to 0x41 -> BRESP = 2'b10, register 0 unchanged.
